// File: rtl/writeback_stage.sv
// Writeback stage: registers the memory-stage result for the GPR write port.
// It also contains a 32-cycle restoring signed divider that drives HI/LO.
module writeback_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        valid_m,
  input  logic        reg_write_m,
  input  logic        mem_to_reg_m,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] read_data_m,
  input  logic [4:0]  write_reg_m,
  input  logic        has_div_m,
  input  logic [31:0] div_dividend_m,
  input  logic [31:0] div_divisor_m,
  output logic        reg_write_w,
  output logic [4:0]  writeback_id,
  output logic [31:0] writeback_value,
  output logic        has_div_w,
  output logic [31:0] div_hi_w,
  output logic [31:0] div_lo_w,
  output logic        div_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [4:0]  count_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        dvsr_zero_q;

  logic        start;
  logic [31:0] abs_dvd;
  logic [31:0] abs_dvsr;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [32:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] hi_fix;
  logic [31:0] lo_fix;

  assign abs_dvd  = div_dividend_m[31] ? -div_dividend_m : div_dividend_m;
  assign abs_dvsr = div_divisor_m[31]  ? -div_divisor_m  : div_divisor_m;

  assign start = valid_m & has_div_m & (state_q == IDLE);
  // Gated by reset_n so the stall drops the instant reset is asserted.
  assign div_stall = reset_n & ((state_q == BUSY) | start);

  // One restoring step: the dividend bits shift out of quo_q into the remainder.
  always_comb begin
    shifted = {rem_q[31:0], quo_q[31]};
    diff    = shifted - {1'b0, dvsr_q};
    rem_d   = shifted;
    quo_d   = {quo_q[30:0], 1'b0};
    if (!diff[32]) begin
      rem_d = diff;
      quo_d = {quo_q[30:0], 1'b1};
    end
    hi_fix = neg_rem_q ? -rem_d[31:0] : rem_d[31:0];
    lo_fix = dvsr_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_d : quo_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      count_q         <= 5'd0;
      rem_q           <= 33'd0;
      quo_q           <= 32'd0;
      dvsr_q          <= 32'd0;
      neg_quo_q       <= 1'b0;
      neg_rem_q       <= 1'b0;
      dvsr_zero_q     <= 1'b0;
      reg_write_w     <= 1'b0;
      writeback_id    <= 5'd0;
      writeback_value <= 32'd0;
      has_div_w       <= 1'b0;
      div_hi_w        <= 32'd0;
      div_lo_w        <= 32'd0;
    end else begin
      reg_write_w     <= valid_m & reg_write_m & ~has_div_m & ~div_stall;
      writeback_value <= mem_to_reg_m ? read_data_m : alu_out_m;
      writeback_id    <= write_reg_m;
      has_div_w       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q       <= 33'd0;
            quo_q       <= abs_dvd;
            dvsr_q      <= abs_dvsr;
            neg_quo_q   <= div_dividend_m[31] ^ div_divisor_m[31];
            neg_rem_q   <= div_dividend_m[31];
            dvsr_zero_q <= (div_divisor_m == 32'd0);
            count_q     <= 5'd31;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (count_q == 5'd0) begin
            div_hi_w  <= hi_fix;
            div_lo_w  <= lo_fix;
            has_div_w <= 1'b1;
            state_q   <= DONE;
          end else begin
            count_q <= count_q - 5'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: GPR path and signed divider checked against a
// plain-arithmetic reference model.
module tb_writeback_stage;
  logic        clock;
  logic        reset_n;
  logic        valid_m;
  logic        reg_write_m;
  logic        mem_to_reg_m;
  logic [31:0] alu_out_m;
  logic [31:0] read_data_m;
  logic [4:0]  write_reg_m;
  logic        has_div_m;
  logic [31:0] div_dividend_m;
  logic [31:0] div_divisor_m;
  logic        reg_write_w;
  logic [4:0]  writeback_id;
  logic [31:0] writeback_value;
  logic        has_div_w;
  logic [31:0] div_hi_w;
  logic [31:0] div_lo_w;
  logic        div_stall;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  writeback_stage dut (
    .clock(clock), .reset_n(reset_n), .valid_m(valid_m), .reg_write_m(reg_write_m),
    .mem_to_reg_m(mem_to_reg_m), .alu_out_m(alu_out_m), .read_data_m(read_data_m),
    .write_reg_m(write_reg_m), .has_div_m(has_div_m), .div_dividend_m(div_dividend_m),
    .div_divisor_m(div_divisor_m), .reg_write_w(reg_write_w), .writeback_id(writeback_id),
    .writeback_value(writeback_value), .has_div_w(has_div_w), .div_hi_w(div_hi_w),
    .div_lo_w(div_lo_w), .div_stall(div_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} from the architectural rules, not from any datapath.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  task automatic idle_inputs();
    valid_m     = 1'b0;
    has_div_m   = 1'b0;
    reg_write_m = 1'b0;
  endtask

  // Holds a DIV in the memory stage until its result pulse, checking latency,
  // stall length, result, HI/LO hold and the one-cycle pulse width.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b);
    int cyc, stall_cnt, pulse_cyc;
    logic gpr_bad, hold_bad, stall_at_pulse;
    logic [63:0] exp;
    exp = ref_div(a, b);
    valid_m = 1'b1; has_div_m = 1'b1; reg_write_m = 1'b1;
    div_dividend_m = a; div_divisor_m = b;
    #1;
    cyc = 0; stall_cnt = 0; pulse_cyc = -1;
    gpr_bad = 1'b0; hold_bad = 1'b0; stall_at_pulse = 1'b1;
    while (cyc < 60) begin
      if (has_div_w) begin
        pulse_cyc = cyc;
        stall_at_pulse = div_stall;
        break;
      end
      if (div_stall) stall_cnt++;
      if (cyc >= 1 && reg_write_w) gpr_bad = 1'b1;
      if (div_hi_w !== last_hi || div_lo_w !== last_lo) hold_bad = 1'b1;
      @(posedge clock); #1;
      cyc++;
    end
    chk("div_latency", pulse_cyc, 33);
    chk("div_stall_cycles", stall_cnt, 33);
    chk("div_stall_done", {31'd0, stall_at_pulse}, 32'd0);
    chk("div_no_gpr_write", {31'd0, gpr_bad}, 32'd0);
    chk("hilo_hold", {31'd0, hold_bad}, 32'd0);
    chk("div_lo", div_lo_w, exp[31:0]);
    chk("div_hi", div_hi_w, exp[63:32]);
    $display("div %h / %h -> lo=%h hi=%h", a, b, div_lo_w, div_hi_w);
    last_hi = exp[63:32];
    last_lo = exp[31:0];
    @(posedge clock); #1;
    chk("div_pulse_width", {31'd0, has_div_w}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        v, rw, mtr;
    logic        flag;
    reset_n = 1'b0;
    idle_inputs();
    mem_to_reg_m = 1'b0; alu_out_m = '0; read_data_m = '0; write_reg_m = '0;
    div_dividend_m = '0; div_divisor_m = '0;
    #2;
    chk("rst_reg_write", {31'd0, reg_write_w}, 32'd0);
    chk("rst_wb_id", {27'd0, writeback_id}, 32'd0);
    chk("rst_wb_value", writeback_value, 32'd0);
    chk("rst_has_div", {31'd0, has_div_w}, 32'd0);
    chk("rst_hi", div_hi_w, 32'd0);
    chk("rst_lo", div_lo_w, 32'd0);
    chk("rst_stall", {31'd0, div_stall}, 32'd0);
    @(negedge clock); reset_n = 1'b1;

    // Directed GPR writes.
    valid_m = 1'b1; reg_write_m = 1'b1; mem_to_reg_m = 1'b0;
    alu_out_m = 32'h0000_1234; write_reg_m = 5'd8; read_data_m = 32'h0;
    @(posedge clock); #1;
    chk("gpr_alu_we", {31'd0, reg_write_w}, 32'd1);
    chk("gpr_alu_id", {27'd0, writeback_id}, 32'd8);
    chk("gpr_alu_val", writeback_value, 32'h0000_1234);
    $display("gpr alu id=%0d val=%h", writeback_id, writeback_value);
    mem_to_reg_m = 1'b1; read_data_m = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    chk("gpr_load_we", {31'd0, reg_write_w}, 32'd1);
    chk("gpr_load_val", writeback_value, 32'hDEAD_BEEF);
    $display("gpr load id=%0d val=%h", writeback_id, writeback_value);

    // Random non-DIV traffic: never stalled, one-cycle latency.
    for (int i = 0; i < 16; i++) begin
      v = 1'($urandom); rw = 1'($urandom); mtr = 1'($urandom);
      valid_m = v; reg_write_m = rw; mem_to_reg_m = mtr; has_div_m = 1'b0;
      alu_out_m = $urandom; read_data_m = $urandom; write_reg_m = 5'($urandom);
      #1;
      chk("gpr_no_stall", {31'd0, div_stall}, 32'd0);
      @(posedge clock); #1;
      chk("gpr_rand_we", {31'd0, reg_write_w}, {31'd0, v & rw});
      chk("gpr_rand_id", {27'd0, writeback_id}, {27'd0, write_reg_m});
      chk("gpr_rand_val", writeback_value, mtr ? read_data_m : alu_out_m);
      $display("gpr rand we=%0d id=%0d val=%h", reg_write_w, writeback_id, writeback_value);
    end
    idle_inputs();
    @(posedge clock); #1;

    // Directed divides, 100/7 and 9/3 back to back.
    run_div(32'd100, 32'd7);
    run_div(32'd9, 32'd3);
    run_div(32'hFFFF_FFF9, 32'd2);
    run_div(32'd7, 32'hFFFF_FFFE);
    run_div(32'h8000_0000, 32'hFFFF_FFFF);
    run_div(32'd5, 32'd0);
    run_div(32'hFFFF_FFFB, 32'd0);
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 1) ? 32'($urandom) : 32'($urandom_range(0, 20)) - 32'd10;
      run_div(a, b);
    end
    idle_inputs();
    @(posedge clock); #1;

    // Reset in BUSY cycle 10 aborts the divide and clears HI/LO.
    valid_m = 1'b1; has_div_m = 1'b1; reg_write_m = 1'b0;
    div_dividend_m = 32'd100; div_divisor_m = 32'd7;
    repeat (10) @(posedge clock);
    #2;
    chk("pre_rst_stall", {31'd0, div_stall}, 32'd1);
    reset_n = 1'b0;
    idle_inputs();
    #1;
    chk("mid_rst_stall", {31'd0, div_stall}, 32'd0);
    chk("mid_rst_has_div", {31'd0, has_div_w}, 32'd0);
    chk("mid_rst_hi", div_hi_w, 32'd0);
    chk("mid_rst_lo", div_lo_w, 32'd0);
    chk("mid_rst_we", {31'd0, reg_write_w}, 32'd0);
    last_hi = 32'd0; last_lo = 32'd0;
    @(negedge clock); reset_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (has_div_w || div_stall) flag = 1'b1;
    end
    chk("post_rst_quiet", {31'd0, flag}, 32'd0);
    run_div(32'd9, 32'd3);
    idle_inputs();
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage: registers the memory-stage result and drives the register-file write port, plus the HI/LO update port, consumed by the decode stage. Also contains the multi-cycle signed divider (DIV) that produces HI/LO. It stalls the upstream pipeline while a divide is in flight.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- valid_m  in  1  memory-stage slot holds a real instruction
- reg_write_m  in  1  instruction writes a GPR
- mem_to_reg_m  in  1  1: write read_data_m; 0: write alu_out_m
- alu_out_m  in  32  ALU result
- read_data_m  in  32  load data
- write_reg_m  in  5  destination GPR id
- has_div_m  in  1  instruction is DIV
- div_dividend_m  in  32  DIV rs operand (signed)
- div_divisor_m  in  32  DIV rt operand (signed)
- reg_write_w  out  1  GPR write enable to decode
- writeback_id  out  5  GPR id to decode
- writeback_value  out  32  GPR data to decode
- has_div_w  out  1  HI/LO write enable to decode, one-cycle pulse
- div_hi_w  out  32  remainder
- div_lo_w  out  32  quotient
- div_stall  out  1  hold fetch/decode/execute/memory stages

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, valid_m & has_div_m: latch |dividend| and |divisor|, plus the sign flags. Load the iteration counter with 31 and go to BUSY.
- BUSY: one restoring shift-subtract step per cycle on a 33-bit partial remainder. At counter==0, apply sign fix-up, register div_hi_w/div_lo_w, and go to DONE.
- Sign rules:
  - quotient is negated iff operand signs differ
  - remainder takes the sign of the dividend
  - magnitudes are 32-bit unsigned; 0x8000_0000 is its own magnitude
  - 0x8000_0000 / -1 gives lo=0x8000_0000, hi=0
- Divisor zero: same latency; lo=0xFFFF_FFFF, hi=dividend.
- DONE: has_div_w=1 for this cycle only. Go to IDLE unconditionally; has_div_m (still asserted by the held DIV) is ignored in DONE.
- div_stall = (state==BUSY) | (state==IDLE & valid_m & has_div_m). It is combinational, so the DIV is held in the memory stage from its first cycle.
- GPR path, every rising edge:
  - reg_write_w <= valid_m & reg_write_m & ~has_div_m & ~div_stall
  - writeback_value <= mem_to_reg_m ? read_data_m : alu_out_m
  - writeback_id <= write_reg_m
- A stall cycle therefore writes a bubble (reg_write_w=0).
- DIV never asserts reg_write_w.
- div_hi_w/div_lo_w hold the last result until the next DIV completes.

## Timing
- Reset (asynchronous, reset_n low): state=IDLE, counter=0, all outputs 0, including div_stall, which falls immediately.
- Reset mid-divide aborts it: no has_div_w pulse, and HI/LO are cleared to 0.
- GPR latency: 1 cycle, memory-stage inputs at edge N appear on outputs after edge N.
- Outputs change only on rising edges. Decode writes the register file on the falling edge, so values are stable half a cycle before use.
- DIV first seen in cycle 0 (IDLE):
  - div_stall high cycles 0..32 (33 cycles)
  - BUSY cycles 1..32
  - DONE cycle 33: has_div_w=1, div_stall=0
  - the pipeline advances at the end of cycle 33
- Back-to-back DIVs: the second DIV enters the memory stage in cycle 34 and is accepted in IDLE that cycle. Its stall begins in cycle 34.
- A non-DIV instruction in the memory stage while IDLE is never stalled.

## Test plan
- GPR write: valid_m=1, reg_write_m=1, mem_to_reg_m=0, alu_out_m=0x0000_1234, write_reg_m=8 -> next cycle reg_write_w=1, writeback_id=8, writeback_value=0x1234. Repeat with mem_to_reg_m=1, read_data_m=0xDEAD_BEEF -> value 0xDEAD_BEEF.
- 100 / 7 -> div_stall high exactly 33 cycles; has_div_w one pulse in cycle 33 with lo=14, hi=2; reg_write_w=0 throughout.
- Signed: -7 / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. 7 / -2 -> lo=0xFFFF_FFFD, hi=1. 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- Divide by zero: 5 / 0 -> after 33 cycles lo=0xFFFF_FFFF, hi=5; has_div_w pulses once.
- Back-to-back: 100/7 then 9/3 -> two has_div_w pulses, in cycles 33 and 67. Second result lo=3, hi=0; HI/LO hold 14/2 between the pulses.
- Reset mid-divide: drop reset_n in BUSY cycle 10 -> div_stall and all outputs 0 immediately. After release, no has_div_w pulse occurs and state is IDLE.
